// File: rtl/instr_fetch_unit.sv
// ---------------------------------------------------------------------------
// instr_fetch_unit
//   Program counter and fetch stage in front of the instruction memory.
//   The PC is driven to the memory from posedge. The memory updates its output
//   on negedge, and the returned word is captured into the IR on the next
//   posedge. The block also handles stall, taken-branch redirect with a
//   one-cycle flush bubble, and halt detection.
//
// Ports
//   clk           in   1       system clock, all state changes on posedge
//   rst           in   1       synchronous active-high reset
//   run           in   1       leave IDLE and start fetching (level)
//   stall         in   1       hold PC and IR
//   branch_taken  in   1       redirect request from execute
//   branch_target in   ADDR_W  redirect byte address (bit0 forced to 0)
//   mem_inst      in   INST_W  word returned by instruction memory
//   curr_addr     out  ADDR_W  PC, address to instruction memory
//   ir            out  INST_W  captured instruction
//   ir_pc         out  ADDR_W  address the IR word was fetched from
//   ir_valid      out  1       IR holds a live, non-flushed instruction
//   halted        out  1       fetch stopped on HALT_OPCODE
//   misalign      out  1       sticky flag, odd branch_target seen
// ---------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter int unsigned        ADDR_W      = 8,
    parameter int unsigned        INST_W      = 16,
    parameter int unsigned        PC_STEP     = 2,
    parameter logic [ADDR_W-1:0]  RESET_PC    = '0,
    parameter logic [3:0]         HALT_OPCODE = 4'b1100
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic [INST_W-1:0] mem_inst,
    output logic [ADDR_W-1:0] curr_addr,
    output logic [INST_W-1:0] ir,
    output logic [ADDR_W-1:0] ir_pc,
    output logic              ir_valid,
    output logic              halted,
    output logic              misalign
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        HALT
    } state_t;

    state_t            state;
    state_t            next_state;
    logic [ADDR_W-1:0] pc;
    logic              is_halt_word;
    logic              do_branch;
    logic              do_capture;

    assign is_halt_word = (mem_inst[INST_W-1:INST_W-4] == HALT_OPCODE);
    assign curr_addr    = pc;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; a branch on the same edge as a halt word wins
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (run) next_state = FETCH;
            FETCH:   if (!branch_taken && !stall && is_halt_word) next_state = HALT;
            HALT:    next_state = HALT;
            default: next_state = IDLE;
        endcase
    end

    // Output / datapath-control decode
    always_comb begin
        halted     = 1'b0;
        do_branch  = 1'b0;
        do_capture = 1'b0;
        case (state)
            FETCH: begin
                do_branch  = branch_taken;
                do_capture = !branch_taken && !stall;
            end
            HALT:    halted = 1'b1;
            default: ;
        endcase
    end

    // PC / IR datapath. A stall in FETCH falls through every branch and holds
    // all registers, including ir_valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc       <= RESET_PC;
            ir       <= '0;
            ir_pc    <= '0;
            ir_valid <= 1'b0;
            misalign <= 1'b0;
        end else if (do_branch) begin
            pc       <= {branch_target[ADDR_W-1:1], 1'b0};
            ir_valid <= 1'b0;
            if (branch_target[0]) misalign <= 1'b1;
        end else if (do_capture) begin
            ir       <= mem_inst;
            ir_pc    <= pc;
            ir_valid <= 1'b1;
            if (!is_halt_word) pc <= pc + ADDR_W'(PC_STEP);
        end else if (state != FETCH) begin
            ir_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        run = 1'b0;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [7:0]  branch_target = '0;
    logic [15:0] mem_inst = '0;
    logic [7:0]  curr_addr;
    logic [15:0] ir;
    logic [7:0]  ir_pc;
    logic        ir_valid;
    logic        halted;
    logic        misalign;

    instr_fetch_unit #(
        .ADDR_W(8),
        .INST_W(16),
        .PC_STEP(2),
        .RESET_PC(8'h00),
        .HALT_OPCODE(4'b1100)
    ) dut (
        .clk(clk),
        .rst(rst),
        .run(run),
        .stall(stall),
        .branch_taken(branch_taken),
        .branch_target(branch_target),
        .mem_inst(mem_inst),
        .curr_addr(curr_addr),
        .ir(ir),
        .ir_pc(ir_pc),
        .ir_valid(ir_valid),
        .halted(halted),
        .misalign(misalign)
    );

    always #5 clk = ~clk;

    // Instruction memory: output updates on negedge from the current address
    logic [15:0] mem [0:255];
    always @(negedge clk) mem_inst <= mem[curr_addr];

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: fetch behaviour expressed as per-edge rules
    bit         m_started, m_halted, m_v, m_mis;
    logic [7:0] m_pc, m_irpc;
    logic [15:0] m_ir;

    task automatic model_edge(input logic r, input logic ru, input logic st,
                              input logic bt, input logic [7:0] tg);
        logic [15:0] w;
        if (r) begin
            m_started = 0; m_halted = 0; m_v = 0; m_mis = 0;
            m_pc = 8'h00; m_ir = 16'h0; m_irpc = 8'h00;
        end else if (m_halted) begin
            m_v = 0;
        end else if (!m_started) begin
            if (ru) m_started = 1;
        end else if (bt) begin
            m_pc = tg & 8'hFE;
            m_v  = 0;
            if (tg % 2 == 1) m_mis = 1;
        end else if (!st) begin
            w = mem[m_pc];
            m_ir = w; m_irpc = m_pc; m_v = 1;
            if (w[15:12] == 4'hC) m_halted = 1;
            else m_pc = 8'((m_pc + 2) % 256);
        end
    endtask

    task automatic compare_all();
        check("curr_addr", 32'(curr_addr), 32'(m_pc));
        check("ir",        32'(ir),        32'(m_ir));
        check("ir_pc",     32'(ir_pc),     32'(m_irpc));
        check("ir_valid",  32'(ir_valid),  32'(m_v));
        check("halted",    32'(halted),    32'(m_halted));
        check("misalign",  32'(misalign),  32'(m_mis));
    endtask

    task automatic step(input logic r, input logic ru, input logic st,
                        input logic bt, input logic [7:0] tg);
        @(negedge clk);
        rst = r; run = ru; stall = st; branch_taken = bt; branch_target = tg;
        @(posedge clk);
        model_edge(r, ru, st, bt, tg);
        #1;
        compare_all();
    endtask

    initial begin
        for (int a = 0; a < 256; a++) mem[a] = {8'h10, 8'(a)};
        mem[8'h40] = 16'hC000;

        // Reset and idle
        step(1, 0, 0, 0, 8'h00);
        step(1, 0, 0, 0, 8'h00);
        check("rst_addr", 32'(curr_addr), 32'h00);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 8'h00);
        check("idle_ir", 32'(ir), 32'h0);

        // Sequential fetch to 08
        step(0, 1, 0, 0, 8'h00);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 8'h00);
        check("seq_addr", 32'(curr_addr), 32'h08);
        check("seq_irpc", 32'(ir_pc), 32'h06);

        // Stall at 08, then resume
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 8'h00);
        check("stall_addr", 32'(curr_addr), 32'h08);
        step(0, 0, 0, 0, 8'h00);
        check("resume_irpc", 32'(ir_pc), 32'h08);

        // Advance to 20 with a bounded wait
        begin
            int n = 0;
            while (m_pc != 8'h20 && n < 40) begin
                step(0, 0, 0, 0, 8'h00);
                n++;
            end
            check("reach_20", 32'(curr_addr), 32'h20);
        end

        // Branch, branch under stall, odd target
        step(0, 0, 0, 1, 8'h24);
        check("br_valid", 32'(ir_valid), 32'h0);
        step(0, 0, 0, 0, 8'h00);
        check("br_irpc", 32'(ir_pc), 32'h24);
        step(0, 0, 1, 1, 8'h30);
        check("br_stall", 32'(curr_addr), 32'h30);
        step(0, 0, 0, 0, 8'h00);
        step(0, 0, 0, 1, 8'h25);
        check("odd_addr", 32'(curr_addr), 32'h24);
        for (int i = 0; i < 2; i++) step(0, 0, 0, 0, 8'h00);
        check("mis_sticky", 32'(misalign), 32'h1);

        // Wrap FE -> 00
        step(0, 0, 0, 1, 8'hFE);
        step(0, 0, 0, 0, 8'h00);
        check("wrap_addr", 32'(curr_addr), 32'h00);

        // Halt at 40, then reset
        step(0, 0, 0, 1, 8'h3E);
        step(0, 0, 0, 0, 8'h00);
        step(0, 0, 0, 0, 8'h00);
        check("halt_ir", 32'(ir), 32'hC000);
        check("halt_valid1", 32'(ir_valid), 32'h1);
        step(0, 1, 0, 0, 8'h00);
        check("halt_flag", 32'(halted), 32'h1);
        check("halt_addr", 32'(curr_addr), 32'h40);
        step(0, 1, 0, 1, 8'h10);
        check("halt_frozen", 32'(curr_addr), 32'h40);
        step(1, 0, 0, 0, 8'h00);
        check("rst_halted", 32'(halted), 32'h0);

        // Randomized phase with occasional halt words
        for (int a = 0; a < 256; a++)
            mem[a] = ($urandom_range(0, 19) == 0) ? {4'hC, 12'($urandom)}
                                                   : {4'(($urandom_range(0, 10) + 13) % 16), 12'($urandom)};
        for (int i = 0; i < 500; i++)
            step($urandom_range(0, 39) == 0, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 6) == 0, 8'($urandom));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
